// File: rtl/e_md_controller.sv
// ============================================================================
// Module   : e_md_controller
// Purpose  : E-stage instruction register, decode and multiply/divide sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_md_controller #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    input  logic        en,
    input  logic        flush,
    output logic [31:0] instr_e,
    output logic [1:0]  tnew,
    output logic [4:0]  a3,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        slt_sel,
    output logic        jal_sel,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        md_busy,
    output logic [1:0]  hilo_we,
    output logic [1:0]  hilo_rd,
    output logic        md_stall
);

    localparam logic [5:0] c_op_special = 6'h00;
    localparam logic [5:0] c_op_jal     = 6'h03;
    localparam logic [5:0] c_op_ori     = 6'h0D;
    localparam logic [5:0] c_op_lui     = 6'h0F;
    localparam logic [5:0] c_op_lw      = 6'h23;
    localparam logic [5:0] c_op_sw      = 6'h2B;

    localparam logic [5:0] c_fn_mfhi    = 6'h10;
    localparam logic [5:0] c_fn_mthi    = 6'h11;
    localparam logic [5:0] c_fn_mflo    = 6'h12;
    localparam logic [5:0] c_fn_mtlo    = 6'h13;
    localparam logic [5:0] c_fn_mult    = 6'h18;
    localparam logic [5:0] c_fn_multu   = 6'h19;
    localparam logic [5:0] c_fn_div     = 6'h1A;
    localparam logic [5:0] c_fn_divu    = 6'h1B;
    localparam logic [5:0] c_fn_addu    = 6'h21;
    localparam logic [5:0] c_fn_subu    = 6'h23;
    localparam logic [5:0] c_fn_slt     = 6'h2A;

    localparam logic [CNT_W-1:0] c_mult_cnt = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] c_div_cnt  = CNT_W'(DIV_CYCLES);

    function automatic logic is_md(input logic [31:0] i);
        return (i[31:26] == c_op_special) &&
               (i[5:0] == c_fn_mult || i[5:0] == c_fn_multu ||
                i[5:0] == c_fn_div  || i[5:0] == c_fn_divu);
    endfunction

    function automatic logic is_hilo(input logic [31:0] i);
        return (i[31:26] == c_op_special) &&
               (i[5:0] == c_fn_mfhi || i[5:0] == c_fn_mflo ||
                i[5:0] == c_fn_mthi || i[5:0] == c_fn_mtlo);
    endfunction

    logic [31:0]      instr_e_q, instr_e_d;
    logic             fresh_q, fresh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             w_unused_d;

    // Only opcode and funct of the D-stage word matter for the stall check
    assign w_unused_d = ^instr_d[25:6];

    always_comb begin
        instr_e_d = instr_e_q;
        fresh_d   = 1'b0;
        if (flush) begin
            instr_e_d = '0;
        end else if (en) begin
            instr_e_d = instr_d;
            fresh_d   = 1'b1;
        end
    end

    // fresh gates the start so a held MD instruction issues only once
    assign md_start = fresh_q & is_md(instr_e_q);
    assign md_busy  = (cnt_q != '0);
    assign md_stall = (is_md(instr_d) | is_hilo(instr_d)) & (md_start | md_busy);

    always_comb begin
        cnt_d = cnt_q;
        if (md_start) begin
            cnt_d = instr_e_q[1] ? c_div_cnt : c_mult_cnt;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_e_q <= '0;
            fresh_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            instr_e_q <= instr_e_d;
            fresh_q   <= fresh_d;
            cnt_q     <= cnt_d;
        end
    end

    assign instr_e = instr_e_q;

    always_comb begin
        tnew    = 2'd0;
        a3      = 5'd0;
        alu_src = 1'b0;
        alu_op  = 3'b000;
        slt_sel = 1'b0;
        jal_sel = 1'b0;
        md_op   = 2'b00;
        hilo_we = 2'b00;
        hilo_rd = 2'b00;
        case (instr_e_q[31:26])
            c_op_special: begin
                case (instr_e_q[5:0])
                    c_fn_addu: begin alu_op = 3'b010; a3 = instr_e_q[15:11]; tnew = 2'd1; end
                    c_fn_subu: begin alu_op = 3'b011; a3 = instr_e_q[15:11]; tnew = 2'd1; end
                    c_fn_slt: begin
                        slt_sel = 1'b1;
                        a3      = instr_e_q[15:11];
                        tnew    = 2'd1;
                    end
                    c_fn_mfhi: begin hilo_rd = 2'b10; a3 = instr_e_q[15:11]; tnew = 2'd1; end
                    c_fn_mflo: begin hilo_rd = 2'b01; a3 = instr_e_q[15:11]; tnew = 2'd1; end
                    c_fn_mthi:  hilo_we = 2'b10;
                    c_fn_mtlo:  hilo_we = 2'b01;
                    c_fn_mult:  md_op = 2'b00;
                    c_fn_multu: md_op = 2'b01;
                    c_fn_div:   md_op = 2'b10;
                    c_fn_divu:  md_op = 2'b11;
                    default: ;
                endcase
            end
            c_op_ori: begin alu_op = 3'b001; alu_src = 1'b1; a3 = instr_e_q[20:16]; tnew = 2'd1; end
            c_op_lui: begin alu_op = 3'b010; alu_src = 1'b1; a3 = instr_e_q[20:16]; tnew = 2'd1; end
            c_op_lw:  begin alu_op = 3'b010; alu_src = 1'b1; a3 = instr_e_q[20:16]; tnew = 2'd2; end
            c_op_sw:  begin alu_op = 3'b010; alu_src = 1'b1; end
            c_op_jal: begin jal_sel = 1'b1; a3 = 5'd31; end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_e_md_controller.sv
// ============================================================================
// Module   : tb_e_md_controller
// Purpose  : Randomized and directed self-checking bench for e_md_controller
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_md_controller;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_d = '0;

    logic [31:0] instr_e;
    logic [1:0]  tnew, md_op, hilo_we, hilo_rd;
    logic [4:0]  a3;
    logic [2:0]  alu_op;
    logic        alu_src, slt_sel, jal_sel, md_start, md_busy, md_stall;

    e_md_controller #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .en(en), .flush(flush),
        .instr_e(instr_e), .tnew(tnew), .a3(a3), .alu_src(alu_src), .alu_op(alu_op),
        .slt_sel(slt_sel), .jal_sel(jal_sel), .md_start(md_start), .md_op(md_op),
        .md_busy(md_busy), .hilo_we(hilo_we), .hilo_rd(hilo_rd), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    wire [18:0] dut_dec = {tnew, a3, alu_src, alu_op, slt_sel, jal_sel, md_op, hilo_we, hilo_rd};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- instruction builders ----------------
    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    // ---------------- reference model ----------------
    function automatic bit ref_is_md(input logic [31:0] i);
        return i[31:26] == 6'h00 && (i[5:0] inside {6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic bit ref_needs_md(input logic [31:0] i);
        return i[31:26] == 6'h00 && (i[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13,
                                                   6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    function automatic int ref_latency(input logic [31:0] i);
        return (i[5:0] == 6'h18 || i[5:0] == 6'h19) ? MULT_CYCLES : DIV_CYCLES;
    endfunction

    // {tnew, a3, alu_src, alu_op, slt_sel, jal_sel, md_op, hilo_we, hilo_rd}
    function automatic logic [18:0] ref_dec(input logic [31:0] i);
        logic [1:0] tn = 0, mo = 0, we = 0, rdsel = 0;
        logic [4:0] dst = 0;
        logic [2:0] aop = 0;
        logic src = 0, slt = 0, jal = 0;
        logic [4:0] rd = i[15:11];
        logic [4:0] rt = i[20:16];
        if (i[31:26] == 6'h00) begin
            case (i[5:0])
                6'h21: begin aop = 3'b010; dst = rd; tn = 1; end
                6'h23: begin aop = 3'b011; dst = rd; tn = 1; end
                6'h2A: begin slt = 1; dst = rd; tn = 1; end
                6'h10: begin rdsel = 2'b10; dst = rd; tn = 1; end
                6'h12: begin rdsel = 2'b01; dst = rd; tn = 1; end
                6'h11: we = 2'b10;
                6'h13: we = 2'b01;
                6'h18: mo = 2'b00;
                6'h19: mo = 2'b01;
                6'h1A: mo = 2'b10;
                6'h1B: mo = 2'b11;
                default: ;
            endcase
        end else begin
            case (i[31:26])
                6'h0D: begin aop = 3'b001; src = 1; dst = rt; tn = 1; end
                6'h0F: begin aop = 3'b010; src = 1; dst = rt; tn = 1; end
                6'h23: begin aop = 3'b010; src = 1; dst = rt; tn = 2; end
                6'h2B: begin aop = 3'b010; src = 1; end
                6'h03: begin jal = 1; dst = 5'd31; end
                default: ;
            endcase
        end
        return {tn, dst, src, aop, slt, jal, mo, we, rdsel};
    endfunction

    // Busy is tracked as "busy through edge number busy_last"
    logic [31:0] m_instr;
    bit          m_fresh;
    int          cyc;
    int          busy_last;

    function automatic bit exp_start();
        return m_fresh && ref_is_md(m_instr);
    endfunction

    function automatic bit exp_busy();
        return cyc <= busy_last;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_instr   = '0;
            m_fresh   = 0;
            cyc       = 0;
            busy_last = -1;
        end else begin
            if (exp_start()) busy_last = cyc + ref_latency(m_instr);
            cyc++;
            if (flush) begin
                m_instr = '0;
                m_fresh = 0;
            end else if (en) begin
                m_instr = instr_d;
                m_fresh = 1;
            end else begin
                m_fresh = 0;
            end
        end
    end

    bit chk_on = 0;

    always @(negedge clk) begin
        if (chk_on && !reset) begin
            check("instr_e", instr_e, m_instr);
            check("decode", 32'(dut_dec), 32'(ref_dec(m_instr)));
            check("md_start", 32'(md_start), 32'(exp_start()));
            check("md_busy", 32'(md_busy), 32'(exp_busy()));
            check("md_stall", 32'(md_stall), 32'(ref_needs_md(instr_d) && (exp_start() || exp_busy())));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic e, input logic f);
        @(negedge clk);
        #1;
        instr_d = i;
        en      = e;
        flush   = f;
    endtask

    function automatic logic [31:0] rand_instr();
        int rs = $urandom_range(0, 31);
        int rt = $urandom_range(0, 31);
        int rd = $urandom_range(0, 31);
        int im = $urandom_range(0, 65535);
        logic [5:0] md_fn [4] = '{6'h18, 6'h19, 6'h1A, 6'h1B};
        case ($urandom_range(0, 18))
            0:  return rtype(rs, rt, rd, 6'h21);
            1:  return rtype(rs, rt, rd, 6'h23);
            2:  return rtype(rs, rt, rd, 6'h2A);
            3:  return itype(6'h0D, rs, rt, im);
            4:  return itype(6'h0F, 0, rt, im);
            5:  return itype(6'h23, rs, rt, im);
            6:  return itype(6'h2B, rs, rt, im);
            7:  return {6'h03, 26'($urandom)};
            8:  return rtype(0, 0, rd, 6'h10);
            9:  return rtype(0, 0, rd, 6'h12);
            10: return rtype(rs, 0, 0, 6'h11);
            11: return rtype(rs, 0, 0, 6'h13);
            12, 13, 14: return rtype(rs, rt, 0, md_fn[$urandom_range(0, 3)]);
            15: return itype(6'h04, rs, rt, im);
            16: return {6'h02, 26'($urandom)};
            17: return rtype(rs, 0, 0, 6'h08);
            default: return ($urandom_range(0, 1) == 0) ? 32'h0 : {6'h3F, 26'($urandom)};
        endcase
    endfunction

    localparam logic [31:0] I_ADDU = 32'h0022_1821;  // addu $3,$1,$2
    localparam logic [31:0] I_LW   = 32'h8C25_0004;  // lw $5,4($1)
    localparam logic [31:0] I_JAL  = 32'h0C00_0040;
    localparam logic [31:0] I_MULT = 32'h0022_0018;  // mult $1,$2
    localparam logic [31:0] I_DIV  = 32'h0022_001A;  // div $1,$2
    localparam logic [31:0] I_MFLO = 32'h0000_2012;  // mflo $4
    localparam logic [31:0] I_MFHI = 32'h0000_2010;  // mfhi $4
    localparam logic [31:0] I_ORI  = 32'h3422_0005;  // ori $2,$1,5

    initial begin
        #3;
        check("rst_instr_e", instr_e, 32'h0);
        check("rst_decode", 32'(dut_dec), 32'h0);
        check("rst_md", 32'({md_start, md_busy, md_stall}), 32'h0);
        @(negedge clk);
        reset  = 1'b0;
        chk_on = 1;

        drive(I_ADDU, 1, 0); tick();
        check("addu_alu_op", 32'(alu_op), 32'h2);
        check("addu_a3", 32'(a3), 32'd3);
        check("addu_tnew_src", 32'({tnew, alu_src}), 32'({2'd1, 1'b0}));
        drive(I_LW, 1, 0); tick();
        check("lw_a3_tnew_src", 32'({a3, tnew, alu_src}), 32'({5'd5, 2'd2, 1'b1}));
        drive(I_JAL, 1, 0); tick();
        check("jal_a3_sel", 32'({a3, jal_sel}), 32'({5'd31, 1'b1}));

        // mult issued, then held in E for several cycles
        drive(I_MULT, 1, 0); tick();
        check("mult_start", 32'({md_start, md_op}), 32'({1'b1, 2'b00}));
        drive(32'h0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("mult_nodouble", 32'(md_start), 32'h0);
            check("mult_busy", 32'(md_busy), 32'(k <= MULT_CYCLES));
        end

        // div with dependent mflo stalled in D; E is flushed while busy
        drive(I_DIV, 1, 0); tick();
        instr_d = I_MFLO; en = 0; flush = 1;
        #1;
        check("div_start_stall", 32'({md_start, md_stall}), 32'h3);
        for (int k = 1; k <= 11; k++) begin
            tick();
            check("div_stall", 32'(md_stall), 32'(k <= DIV_CYCLES));
        end
        en = 1; flush = 0;
        tick();
        check("mflo_decode", 32'({hilo_rd, a3, tnew}), 32'({2'b01, 5'd4, 2'd1}));

        drive(I_ORI, 1, 1); tick();
        check("flush_prio", instr_e, 32'h0);

        // asynchronous reset in the middle of a mult
        drive(I_MULT, 1, 0); tick();
        drive(32'h0, 0, 0);
        tick(); tick(); tick();
        instr_d = I_MFHI;
        #1;
        check("pre_rst_busy_stall", 32'({md_busy, md_stall}), 32'h3);
        reset = 1'b1;
        #1;
        check("rst_mid_md", 32'({md_start, md_busy, md_stall}), 32'h0);
        check("rst_mid_instr", instr_e, 32'h0);
        check("rst_mid_decode", 32'(dut_dec), 32'h0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // randomized traffic, hazard unit behaviour mimicked on stall
        for (int c = 0; c < 3000; c++) begin
            drive(rand_instr(), 0, 0);
            if (ref_needs_md(instr_d) && (exp_start() || exp_busy())) begin
                en = 0; flush = 1;
            end else begin
                en    = ($urandom_range(0, 3) != 0);
                flush = ($urandom_range(0, 9) == 0);
            end
        end
        @(negedge clk);
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/e_md_controller.md
Name: e_md_controller

Overview:
- Next-generation execute-stage controller for the 5-stage MIPS32 pipeline.
- Owns the D->E instruction register and decodes the E-stage instruction into ALU, forwarding and hazard information.
- Sequences a multi-cycle multiply/divide unit with parametrised latencies and generates the HI/LO controls.
- Raises the D-stage stall request for multiply/divide-class hazards. Sits between the D-stage hazard unit and the ALU / MD datapath.

Parameters:
- MULT_CYCLES, 5: busy cycles after a mult/multu start (1..15).
- DIV_CYCLES, 10: busy cycles after a div/divu start (1..15).
- CNT_W, 4: busy-counter width. Must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- instr_d  input  32  D-stage instruction
- en  input  1  advance D->E (load instr_d)
- flush  input  1  insert bubble into E
- instr_e  output  32  registered E-stage instruction
- tnew  output  2  cycles until E result is available
- a3  output  5  destination register (0 = none)
- alu_src  output  1  1 = immediate operand
- alu_op  output  3  ALU function
- slt_sel  output  1  select compare result
- jal_sel  output  1  select PC+8 as result
- md_start  output  1  one-cycle start pulse to the MD unit
- md_op  output  2  00 mult, 01 multu, 10 div, 11 divu
- md_busy  output  1  MD unit computing
- hilo_we  output  2  [1] write HI, [0] write LO (mthi/mtlo)
- hilo_rd  output  2  01 mflo, 10 mfhi, 00 none
- md_stall  output  1  stall request for D stage

Behaviour:
- Instruction register. Clock and reset are fixed:
  - One clock, clk.
  - reset is asynchronous and active-high.
  - On reset: instr_e=0, fresh=0, cnt=0.
- Each rising edge:
  - flush=1 -> instr_e<=0 and fresh<=0. flush has priority over en.
  - else en=1 -> instr_e<=instr_d and fresh<=1.
  - else hold instr_e; fresh<=0.
- Decode of instr_e is combinational. Opcode and funct values are standard MIPS.
  - addu: alu_op=010, a3=rd, tnew=1.
  - subu: alu_op=011, a3=rd, tnew=1.
  - slt: alu_op=000, slt_sel=1, a3=rd, tnew=1.
  - ori: alu_op=001, alu_src=1, a3=rt, tnew=1.
  - lui: alu_op=010, alu_src=1, a3=rt, tnew=1.
  - lw: alu_op=010, alu_src=1, a3=rt, tnew=2.
  - sw: alu_op=010, alu_src=1, a3=0, tnew=0.
  - jal: jal_sel=1, a3=31, tnew=0.
  - mfhi / mflo: a3=rd, tnew=1, hilo_rd=10 / 01.
  - mthi / mtlo: hilo_we=10 / 01, a3=0.
  - mult / multu / div / divu: md_op per port encoding, a3=0, tnew=0.
  - beq, j, jr, nop and unknown: every decode output is 0.
- Reset values: every decode output is 0, because instr_e=0. md_start=0, md_busy=0, md_stall=0.
- md_start = fresh AND instr_e is mult/multu/div/divu.
  - Exactly one pulse per issued MD instruction, even when E holds for several cycles.
- Busy counter cnt:
  - md_start -> cnt<=MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu).
  - else if cnt!=0 -> cnt<=cnt-1.
  - md_busy = (cnt!=0). It is high for exactly the configured number of cycles following the start cycle.
- md_stall = (instr_d is mult/multu/div/divu/mfhi/mflo/mthi/mtlo) AND (md_start OR md_busy).
  - Combinational.
  - The hazard unit drives en=0 and flush=1 while it is high.
- Boundary cases:
  - flush while busy: the counter keeps running, because the unit is already committed.
  - reset mid-operation: cnt=0 and md_busy=0 immediately. No pending start.
  - Back-to-back MD instructions: the second is stalled in D until md_busy=0. It then issues and md_start fires on the cycle after the load.
  - mthi/mtlo in E while busy is impossible, because D stall prevents it. No check is required.
  - Counter saturation: none. Parameters are restricted to values below 2^CNT_W.

Test Plan:
- Reset mid-op: reset asserted while md_busy=1, cnt=3 -> md_busy, md_stall, instr_e and every decode output are 0 asynchronously, before the next edge.
- ALU decode: load addu $3,$1,$2 -> alu_op=010, a3=3, tnew=1, alu_src=0. Load lw $5,4($1) -> a3=5, tnew=2, alu_src=1. Load jal -> a3=31, jal_sel=1.
- Multiply latency: issue mult $1,$2 with en=1 -> md_start high for exactly 1 cycle, md_op=00. md_busy is then high for exactly 5 cycles and low on the 6th.
- Divide + dependent mflo in D: div issued, mflo $4 held in D -> md_stall=1 from the start cycle through 10 busy cycles. It drops when cnt=0, and mflo then decodes hilo_rd=01, a3=4.
- Hold without double start: mult in E with en=0, flush=0 for 3 cycles -> a single md_start pulse, and cnt is not reloaded.
- Flush priority: en=1 and flush=1 together with instr_d=ori -> instr_e=0. Flush while md_busy -> the counter continues to 0, and md_stall for a D-stage mfhi stays high until busy clears.
